// File: rtl/timing_error_monitor.sv
// Multi-bit main/shadow timing error monitor with replay handshake and error counter.
// Optional sticky first-error log enabled by defining TIMING_ERR_LOG_EN.
module timing_error_monitor #(
    parameter int WIDTH   = 32,
    parameter int CNT_W   = 16,
    parameter int HOLDOFF = 2,
    parameter int THRESH  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid,
    input  logic [WIDTH-1:0] data,
    input  logic [WIDTH-1:0] data_shadow,
    input  logic             clr,
    input  logic             replay_ack,
    output logic             error,
    output logic [WIDTH-1:0] error_vec,
    output logic             stall,
    output logic             replay_req,
    output logic [CNT_W-1:0] err_count,
    output logic             err_sticky,
    output logic             thresh_hit
`ifdef TIMING_ERR_LOG_EN
    ,
    output logic [WIDTH-1:0] log_vec,
    output logic             log_valid
`endif
);

    localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic [HW-1:0] HO_LOAD =
        (HOLDOFF > 0) ? HW'(HOLDOFF - 1) : '0;
    localparam logic [CNT_W:0] TH = (CNT_W + 1)'(THRESH);

    typedef enum logic [1:0] {
        IDLE,
        REPLAY,
        HOLD
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [HW-1:0]    ho_cnt;
    logic [HW-1:0]    ho_cnt_n;
    logic [WIDTH-1:0] q;
    logic             valid_q;
    logic [WIDTH-1:0] diff;
    logic             accept;
    logic             sat;

    assign diff   = q ^ data_shadow;
    assign accept = valid_q && (|diff) && (state == IDLE);
    assign sat    = &err_count;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= IDLE;
            ho_cnt <= '0;
        end else begin
            state  <= state_n;
            ho_cnt <= ho_cnt_n;
        end
    end

    always_comb begin
        state_n    = state;
        ho_cnt_n   = ho_cnt;
        stall      = 1'b0;
        replay_req = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) state_n = REPLAY;
            end
            REPLAY: begin
                stall      = 1'b1;
                replay_req = 1'b1;
                if (replay_ack) begin
                    if (HOLDOFF == 0) begin
                        state_n = IDLE;
                    end else begin
                        state_n  = HOLD;
                        ho_cnt_n = HO_LOAD;
                    end
                end
            end
            HOLD: begin
                stall = 1'b1;
                if (ho_cnt == '0) state_n = IDLE;
                else ho_cnt_n = ho_cnt - 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            q         <= '0;
            valid_q   <= 1'b0;
            error     <= 1'b0;
            error_vec <= '0;
        end else begin
            q         <= data;
            valid_q   <= valid;
            error     <= accept;
            error_vec <= accept ? diff : '0;
        end
    end

    // clr outranks a same-cycle event for the statistics only
    always_ff @(posedge clk) begin
        if (!reset) begin
            err_count  <= '0;
            err_sticky <= 1'b0;
            thresh_hit <= 1'b0;
        end else if (clr) begin
            err_count  <= '0;
            err_sticky <= 1'b0;
            thresh_hit <= 1'b0;
        end else begin
            if (accept && !sat) err_count <= err_count + 1'b1;
            if (accept) err_sticky <= 1'b1;
            thresh_hit <= ({1'b0, err_count} >= TH);
        end
    end

`ifdef TIMING_ERR_LOG_EN
    always_ff @(posedge clk) begin
        if (!reset || clr) begin
            log_vec   <= '0;
            log_valid <= 1'b0;
        end else if (accept && !log_valid) begin
            log_vec   <= diff;
            log_valid <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_timing_error_monitor.sv
// Scoreboard bench for timing_error_monitor (WIDTH=8, CNT_W=2, HOLDOFF=2, THRESH=3).
module tb_timing_error_monitor;

    localparam int WIDTH   = 8;
    localparam int CNT_W   = 2;
    localparam int HOLDOFF = 2;
    localparam int THRESH  = 3;
    localparam int CMAX    = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             valid;
    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] data_shadow;
    logic             clr;
    logic             replay_ack;
    logic             error;
    logic [WIDTH-1:0] error_vec;
    logic             stall;
    logic             replay_req;
    logic [CNT_W-1:0] err_count;
    logic             err_sticky;
    logic             thresh_hit;

    timing_error_monitor #(
        .WIDTH  (WIDTH),
        .CNT_W  (CNT_W),
        .HOLDOFF(HOLDOFF),
        .THRESH (THRESH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .valid      (valid),
        .data       (data),
        .data_shadow(data_shadow),
        .clr        (clr),
        .replay_ack (replay_ack),
        .error      (error),
        .error_vec  (error_vec),
        .stall      (stall),
        .replay_req (replay_req),
        .err_count  (err_count),
        .err_sticky (err_sticky),
        .thresh_hit (thresh_hit)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             err;
        logic [WIDTH-1:0] vec;
        logic             stall;
        logic             req;
        logic [CNT_W-1:0] cnt;
        logic             sticky;
        logic             th;
    } exp_t;

    exp_t             expq[$];
    logic [WIDTH-1:0] evq[$];
    int               checks = 0;
    int               errors = 0;

    // reference model: mode 0 compare, 1 waiting for ack, 2 quiet window
    logic [WIDTH-1:0] m_q      = '0;
    logic             m_vq     = 1'b0;
    int               m_mode   = 0;
    int               m_left   = 0;
    int               m_cnt    = 0;
    logic             m_sticky = 1'b0;
    logic             m_th     = 1'b0;
    logic [WIDTH-1:0] prev_d   = '0;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h",
                     nm, $time, act, want);
        end
    endtask

    task automatic model();
        exp_t             e;
        logic [WIDTH-1:0] d;
        logic             acc;
        e.err = 1'b0;
        e.vec = '0;
        if (!reset) begin
            m_q = '0; m_vq = 1'b0; m_mode = 0; m_left = 0;
            m_cnt = 0; m_sticky = 1'b0; m_th = 1'b0;
        end else begin
            d   = m_q ^ data_shadow;
            acc = m_vq && (d != '0) && (m_mode == 0);
            e.err = acc;
            e.vec = acc ? d : '0;
            if (clr) begin
                m_cnt = 0; m_sticky = 1'b0; m_th = 1'b0;
            end else begin
                m_th = (m_cnt >= THRESH);
                if (acc) begin
                    m_sticky = 1'b1;
                    if (m_cnt < CMAX) m_cnt++;
                end
            end
            if (m_mode == 0) begin
                if (acc) m_mode = 1;
            end else if (m_mode == 1) begin
                if (replay_ack) begin
                    m_mode = (HOLDOFF == 0) ? 0 : 2;
                    m_left = HOLDOFF;
                end
            end else begin
                m_left--;
                if (m_left == 0) m_mode = 0;
            end
            m_q  = data;
            m_vq = valid;
        end
        e.stall  = (m_mode != 0);
        e.req    = (m_mode == 1);
        e.cnt    = CNT_W'(m_cnt);
        e.sticky = m_sticky;
        e.th     = m_th;
        expq.push_back(e);
        if (e.err) evq.push_back(e.vec);
    endtask

    task automatic cyc(input logic v, input logic [WIDTH-1:0] d,
                       input logic [WIDTH-1:0] sh, input logic c,
                       input logic a, input logic r);
        valid = v; data = d; data_shadow = sh;
        clr = c; replay_ack = a; reset = r;
        @(posedge clk);
        model();
        #1;
    endtask

    task automatic one_event(input logic do_clr, input logic do_ack);
        logic [WIDTH-1:0] d;
        logic [WIDTH-1:0] m;
        d = WIDTH'($urandom);
        m = WIDTH'($urandom_range(1, 255));
        cyc(1'b1, d, '0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, '0, d ^ m, do_clr, 1'b0, 1'b1);
        cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, '0, '0, 1'b0, do_ack, 1'b1);
        repeat (3) cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                check("error", 32'(error), 32'(e.err));
                check("error_vec", 32'(error_vec), 32'(e.vec));
                check("stall", 32'(stall), 32'(e.stall));
                check("replay_req", 32'(replay_req), 32'(e.req));
                check("err_count", 32'(err_count), 32'(e.cnt));
                check("err_sticky", 32'(err_sticky), 32'(e.sticky));
                check("thresh_hit", 32'(thresh_hit), 32'(e.th));
            end
            if (error === 1'b1) begin
                if (evq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_error at %0t: vec %0h expected none",
                             $time, error_vec);
                end else begin
                    check("event_vec", 32'(error_vec), 32'(evq.pop_front()));
                end
            end
        end
    end

    initial begin : driver
        logic [WIDTH-1:0] d;
        logic [WIDTH-1:0] sh;
        cyc(1'b1, 8'h55, 8'hAA, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 8'hAA, 8'h55, 1'b1, 1'b0, 1'b0);
        repeat (3) cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        repeat (10) cyc(1'b1, 8'hA5, 8'hA5, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, '0, 8'hA4, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 8'hFF, 8'h00, 1'b0, 1'b1, 1'b1);
        cyc(1'b1, 8'hFF, 8'h00, 1'b0, 1'b1, 1'b1);
        cyc(1'b0, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b1);
        repeat (3) cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        repeat (5) one_event(1'b0, 1'b1);
        one_event(1'b1, 1'b1);
        one_event(1'b0, 1'b0);
        cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        one_event(1'b0, 1'b1);
        for (int i = 0; i < 400; i++) begin
            d  = WIDTH'($urandom);
            sh = prev_d;
            if ($urandom_range(0, 2) == 0) sh = sh ^ WIDTH'($urandom);
            cyc(1'($urandom_range(0, 1)), d, sh,
                ($urandom_range(0, 39) == 0),
                ($urandom_range(0, 2) == 0),
                ($urandom_range(0, 99) != 0));
            prev_d = d;
        end
        repeat (4) cyc(1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        #1;
        check("event_queue_drained", 32'(evq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
